dispatch5: RTL
==============

// Module: dispatch5
// PURPOSE
//  1-to-5 result/operand router: accepts one valid/ready stream carrying a
//  3-bit channel select and forwards each beat to exactly one of five output
//  channels through a one-entry holding slot per channel. Used where one
//  producer (issue/writeback stage) feeds five consumers (ALU, MUL/DIV, LSU,
//  CSR, branch unit) that may stall independently. Select encoding matches
//  the 5-way select used elsewhere in the datapath: 0..4 = ch0..ch4;
//  5..7 = ch0 plus an error pulse.
// PARAMETERS
//  DATA_WIDTH  64  payload width per beat
//  CNT_WIDTH   32  width of the accepted-beat counter
// PORTS
//  clk        in   1             single clock; all state updates on posedge
//  rst        in   1             synchronous, active-high reset
//  in_valid   in   1             producer has a beat
//  in_ready   out  1             block accepts the beat this cycle
//  in_sel     in   3             target channel
//  in_data    in   DATA_WIDTH    payload
//  out_valid  out  5             bit i: slot i holds a beat
//  out_ready  in   5             bit i: consumer i takes the beat
//  out_data   out  5*DATA_WIDTH  channel i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//  sel_err    out  1             1-cycle pulse: accepted beat had sel 5..7
//  beat_cnt   out  CNT_WIDTH     total accepted beats, wraps at 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): out_valid=0, out_data=0, sel_err=0,
//    beat_cnt=0. in_ready is combinational and reads 1 during reset.
//    Reset mid-transfer drops all held beats; no output after reset until a
//    new beat is accepted.
//  - tgt = (in_sel <= 4) ? in_sel : 0.
//  - in_ready = !out_valid[tgt] | out_ready[tgt]. This is combinational in
//    in_sel and out_ready[tgt] only, never in in_valid.
//  - accept = in_valid & in_ready. On accept: slot[tgt] <= in_data,
//    out_valid[tgt] <= 1, beat_cnt += 1 (wraps), sel_err <= (in_sel > 4).
//  - Drain: out_valid[i] & out_ready[i] with no fill of i this cycle ->
//    out_valid[i] <= 0. out_data[i] keeps its last value.
//  - Same-slot drain + fill in one cycle: the new beat is loaded and
//    out_valid stays 1. Full throughput is 1 beat/cycle per channel.
//  - Other slots drain independently and concurrently with any fill.
//  - Latency: accepted at edge N -> visible on out_* after edge N (1 cycle).
//  - Full slot with consumer stalled: in_ready=0 for that tgt only. A beat
//    for another, free channel is still accepted. Beats to different
//    channels may complete out of order. Order within a channel is preserved.
//  - out_valid[i] never drops without a handshake. out_data[i] is stable
//    while out_valid[i]=1 and out_ready[i]=0.
//  - in_valid=0: no state change except drains. sel_err is 0 in any cycle
//    without an error accept.
// STRUCTURE
//  - Shared package rv64_dispatch_pkg: NUM_CH=5, SEL_WIDTH=3, localparams
//    CH_ALU=0, CH_MDU=1, CH_LSU=2, CH_CSR=3, CH_BRU=4, CH_DEFAULT=0.
//  - One sub-module, dispatch_slot (one-entry valid/data register with
//    fill/drain logic), instantiated NUM_CH times by generate.
//  - Top level holds: tgt decode, in_ready mux, per-slot fill strobes,
//    sel_err and beat_cnt registers.
// TESTING
//  1. Reset, then in_sel=2, data=64'hDEAD_BEEF, out_ready=5'b11111
//     -> next cycle out_valid=5'b00100, ch2 data=DEAD_BEEF, beat_cnt=1.
//  2. out_ready[1]=0; send two beats to sel=1
//     -> 1st accepted; in_ready=0 for the 2nd until out_ready[1]=1.
//     -> While ch1 is blocked, a sel=3 beat is still accepted.
//  3. Back-to-back beats to sel=4 with out_ready[4]=1 held
//     -> 1 beat/cycle, out_valid[4] stays 1, data sequence preserved.
//  4. in_sel=6, data=5 -> ch0 gets 5 and sel_err pulses for exactly 1 cycle.
//  5. Assert rst while slots 0 and 3 are full
//     -> next cycle out_valid=0, beat_cnt=0. Held beats are never emitted.
//  6. Preload beat_cnt near wrap (CNT_WIDTH=4, 15 beats) then 1 more beat
//     -> beat_cnt=0. Random stall regression checks per-channel order.

Source files
------------

// File: rtl/rv64_dispatch_pkg.sv
// Shared definitions for the 5-way operand/result dispatcher: channel map and select decode.
package rv64_dispatch_pkg;
  localparam int NUM_CH     = 5;
  localparam int SEL_WIDTH  = 3;
  localparam int CH_ALU     = 0;
  localparam int CH_MDU     = 1;
  localparam int CH_LSU     = 2;
  localparam int CH_CSR     = 3;
  localparam int CH_BRU     = 4;
  localparam int CH_DEFAULT = 0;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  localparam sel_t SEL_MAX = sel_t'(NUM_CH - 1);

  function automatic logic sel_is_err(input sel_t sel);
    return sel > SEL_MAX;
  endfunction

  // Out-of-range selects fall back to the default channel
  function automatic sel_t sel_to_tgt(input sel_t sel);
    return sel_is_err(sel) ? sel_t'(CH_DEFAULT) : sel;
  endfunction
endpackage

// File: rtl/dispatch_slot.sv
// One-entry holding slot: a fill loads a beat, a consumer handshake empties it.
module dispatch_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fill,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // A fill wins over a same-cycle drain so the slot sustains one beat per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/dispatch5.sv
// 1-to-5 valid/ready router: each accepted beat lands in the holding slot of its target channel.
module dispatch5
  import rv64_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_WIDTH-1:0]         in_sel,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         sel_err,
  output logic [CNT_WIDTH-1:0]         beat_cnt
);
  sel_t                         w_tgt;
  logic                         w_in_ready;
  logic                         w_accept;
  logic [NUM_CH-1:0]            w_fill;
  logic [NUM_CH-1:0]            w_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] w_data;
  logic                         r_sel_err;
  logic [CNT_WIDTH-1:0]         r_beat_cnt;

  assign w_tgt = sel_to_tgt(in_sel);
  // Ready depends only on the target slot, never on in_valid; forced high while in reset
  assign w_in_ready = rst | ~w_valid[w_tgt] | out_ready[w_tgt];
  assign w_accept   = in_valid & w_in_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    assign w_fill[g] = w_accept & (w_tgt == sel_t'(g));

    dispatch_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_fill (w_fill[g]),
      .i_data (in_data),
      .i_ready(out_ready[g]),
      .o_valid(w_valid[g]),
      .o_data (w_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err  <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_sel_err <= w_accept & sel_is_err(in_sel);
      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_valid;
  assign out_data  = w_data;
  assign sel_err   = r_sel_err;
  assign beat_cnt  = r_beat_cnt;
endmodule
